mem_arbiter: RTL
================

# mem_arbiter

Two-master, one-slave AXI4-Lite arbiter between the core's memory clients and the single memory slave. Master 0 is the instruction fetch unit (read-only) and master 1 is the load/store unit (read and write). Exactly one transaction is in flight at a time. Requests are granted round-robin, and each response is routed back only to the master that issued it.

## Interface
- ADDR_W, 32, address width of every AR/AW channel
- DATA_W, 32, data width; strobe width is DATA_W/8
- clk  in  1  clock; everything is sampled on the rising edge
- rst  in  1  synchronous, active-low reset; rst==0 at a rising edge resets the block
- m0_araddr, m0_arvalid  in  ADDR_W, 1  IFU read-address channel
- m0_arready  out  1  IFU read-address accept
- m0_rdata, m0_rresp, m0_rvalid  out  DATA_W, 2, 1  IFU read-data channel
- m0_rready  in  1  IFU read-data accept
- m1_araddr, m1_arvalid, m1_rready  in  ADDR_W, 1, 1  LSU read request and read-data accept
- m1_arready, m1_rdata, m1_rresp, m1_rvalid  out  1, DATA_W, 2, 1  LSU read accept and read-data channel
- m1_awaddr, m1_awvalid, m1_wdata, m1_wstrb, m1_wvalid, m1_bready  in  ADDR_W, 1, DATA_W, DATA_W/8, 1, 1  LSU write request and response accept
- m1_awready, m1_wready, m1_bresp, m1_bvalid  out  1, 1, 2, 1  LSU write accepts and write response
- s_araddr, s_arvalid, s_rready, s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready  out  (widths as the m1 equivalents)  slave request side
- s_arready, s_rdata, s_rresp, s_rvalid, s_awready, s_wready, s_bresp, s_bvalid  in  (widths as the m1 equivalents)  slave response side

## Operation
- FSM states: IDLE, RADDR, RDATA, WADDR, WRESP.
- Registers: one 1-bit owner, one 1-bit last_grant, latched addr/wdata/wstrb, and the aw_done/w_done flags.
- **IDLE candidates:**
  - R0 = m0_arvalid.
  - R1 = m1_arvalid.
  - W1 = m1_awvalid & m1_wvalid. An AW or W without its partner is not a candidate.
- **Master 1 internal priority:** W1 beats R1.
- **Round-robin between masters:**
  - If master 0 and master 1 both request, the master that is not last_grant wins.
  - A lone requester always wins.
  - last_grant resets to 1, so master 0 wins the first tie.
- **Grant (IDLE, combinational):**
  - The winner's arready, or awready+wready for a write, is asserted in the same cycle.
  - Address/data/strobe are latched, owner and last_grant are updated, and the FSM moves to RADDR or WADDR.
- **RADDR:** s_arvalid=1 with the latched address. On s_arready → RDATA.
- **RDATA:**
  - s_rdata/s_rresp pass combinationally to both mN_rdata/mN_rresp.
  - Only the owner's rvalid is driven from s_rvalid; the other master sees rvalid=0.
  - s_rready = owner's rready.
  - On s_rvalid & s_rready → IDLE.
- **WADDR:**
  - s_awvalid = ~aw_done and s_wvalid = ~w_done.
  - Each flag sets on its own slave handshake, so AW and W may complete in either order or in the same cycle.
  - When both are done, or become done this cycle → WRESP; the flags clear.
- **WRESP:** s_bresp passes through to m1_bresp, m1_bvalid = s_bvalid, s_bready = m1_bready. On handshake → IDLE.
- rresp and bresp are forwarded unchanged; error responses get no special handling.
- Master-side ready signals are 0 in every state except IDLE-grant. New requests wait there, and masters must hold valid stable until accepted.
- **Reset:**
  - FSM → IDLE, last_grant=1, aw_done=w_done=0.
  - All s_*valid, s_rready, s_bready and all master-side ready/valid outputs are 0.
  - Latched data is don't-care.
  - A reset mid-transaction abandons it silently.

## Timing
- Request accepted in cycle 0 (the master handshake completes combinationally) → s_arvalid/s_awvalid first high in cycle 1.
- With a zero-wait slave (s_arready in cycle 1, s_rvalid in cycle 2), the owner's rvalid is high in cycle 2, the FSM is IDLE in cycle 3, and the next grant can happen in cycle 3.
- A write with a zero-wait slave: accept in cycle 0, AW/W in cycle 1, B in cycle 2, IDLE in cycle 3.
- No combinational path from any master input to any s_*valid output: slave valids depend only on FSM state and flags.
- A master rvalid/bvalid held low by its own rready stall keeps the FSM in RDATA/WRESP indefinitely.

## Test plan
- **Lone IFU read:** m0_arvalid=1, araddr=0x8000_0000 in cycle 0; slave returns 0x0000_0413 in cycle 2 → m0_arready=1 in cycle 0, s_araddr=0x8000_0000 in cycle 1, m0_rdata=0x0000_0413 with m0_rvalid=1 in cycle 2, m1_rvalid=0 throughout.
- **Tie after reset:** m0 and m1 read simultaneously → m0 granted first; m1 granted in the IDLE cycle after m0's R handshake; a third simultaneous tie then grants m0 again.
- **LSU write, split slave accepts:** awaddr=0x8000_1000, wdata=0xDEADBEEF, wstrb=4'b0011; slave gives wready in cycle 1 and awready in cycle 3 → s_wvalid drops after cycle 1, s_awvalid stays high through cycle 3, bvalid forwarded, return to IDLE.
- **Response stall:** hold m0_rready=0 for 5 cycles while s_rvalid=1 → s_rready=0 and the FSM stays in RDATA; a simultaneous m1_arvalid sees m1_arready=0 until m0 completes.
- **Error passthrough:** slave returns s_rresp=2'b10 → the owner sees rresp=2'b10 with unchanged timing.
- **Reset mid-write:** rst=0 while in WADDR → next cycle all valid and ready outputs are 0; after rst=1, a tie grants m0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master, one-slave AXI4-Lite arbiter: IFU (read-only) and LSU (read/write)
// share one slave, one transaction in flight, round-robin grant between masters.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   // master 0: instruction fetch
   input  logic [ADDR_W-1:0]   m0_araddr,
   input  logic                m0_arvalid,
   output logic                m0_arready,
   output logic [DATA_W-1:0]   m0_rdata,
   output logic [1:0]          m0_rresp,
   output logic                m0_rvalid,
   input  logic                m0_rready,
   // master 1: load/store
   input  logic [ADDR_W-1:0]   m1_araddr,
   input  logic                m1_arvalid,
   output logic                m1_arready,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic [1:0]          m1_rresp,
   output logic                m1_rvalid,
   input  logic                m1_rready,
   input  logic [ADDR_W-1:0]   m1_awaddr,
   input  logic                m1_awvalid,
   output logic                m1_awready,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wstrb,
   input  logic                m1_wvalid,
   output logic                m1_wready,
   output logic [1:0]          m1_bresp,
   output logic                m1_bvalid,
   input  logic                m1_bready,
   // slave
   output logic [ADDR_W-1:0]   s_araddr,
   output logic                s_arvalid,
   input  logic                s_arready,
   input  logic [DATA_W-1:0]   s_rdata,
   input  logic [1:0]          s_rresp,
   input  logic                s_rvalid,
   output logic                s_rready,
   output logic [ADDR_W-1:0]   s_awaddr,
   output logic                s_awvalid,
   input  logic                s_awready,
   output logic [DATA_W-1:0]   s_wdata,
   output logic [DATA_W/8-1:0] s_wstrb,
   output logic                s_wvalid,
   input  logic                s_wready,
   input  logic [1:0]          s_bresp,
   input  logic                s_bvalid,
   output logic                s_bready
);

   typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WRESP} state_t;

   state_t                state_q, state_d;
   logic                  owner_q, owner_d;
   logic                  last_grant_q, last_grant_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
   logic                  aw_done_q, aw_done_d;
   logic                  w_done_q, w_done_d;

   logic req0, req1, wr1, grant0, grant1;
   logic aw_now, w_now, r_ack;

   // A write needs both AW and W present; a lone AW or W is not a request.
   assign wr1  = m1_awvalid & m1_wvalid;
   assign req0 = m0_arvalid;
   assign req1 = m1_arvalid | wr1;

   // Grants are suppressed while reset is held so no master sees a ready then.
   assign grant0 = (state_q == IDLE) && rst && req0 && (!req1 || last_grant_q);
   assign grant1 = (state_q == IDLE) && rst && req1 && (!req0 || !last_grant_q);

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      aw_done_d    = aw_done_q;
      w_done_d     = w_done_q;
      aw_now       = 1'b0;
      w_now        = 1'b0;
      r_ack        = 1'b0;

      m0_arready = 1'b0;
      m0_rvalid  = 1'b0;
      m1_arready = 1'b0;
      m1_rvalid  = 1'b0;
      m1_awready = 1'b0;
      m1_wready  = 1'b0;
      m1_bvalid  = 1'b0;
      s_arvalid  = 1'b0;
      s_rready   = 1'b0;
      s_awvalid  = 1'b0;
      s_wvalid   = 1'b0;
      s_bready   = 1'b0;

      m0_rdata = s_rdata;
      m0_rresp = s_rresp;
      m1_rdata = s_rdata;
      m1_rresp = s_rresp;
      m1_bresp = s_bresp;
      s_araddr = addr_q;
      s_awaddr = addr_q;
      s_wdata  = wdata_q;
      s_wstrb  = wstrb_q;

      unique case (state_q)
         IDLE: begin
            if (grant0) begin
               m0_arready   = 1'b1;
               addr_d       = m0_araddr;
               owner_d      = 1'b0;
               last_grant_d = 1'b0;
               state_d      = RADDR;
            end else if (grant1) begin
               owner_d      = 1'b1;
               last_grant_d = 1'b1;
               if (wr1) begin
                  m1_awready = 1'b1;
                  m1_wready  = 1'b1;
                  addr_d     = m1_awaddr;
                  wdata_d    = m1_wdata;
                  wstrb_d    = m1_wstrb;
                  state_d    = WADDR;
               end else begin
                  m1_arready = 1'b1;
                  addr_d     = m1_araddr;
                  state_d    = RADDR;
               end
            end
         end
         RADDR: begin
            s_arvalid = 1'b1;
            if (s_arready) state_d = RDATA;
         end
         RDATA: begin
            r_ack     = owner_q ? m1_rready : m0_rready;
            s_rready  = r_ack;
            m0_rvalid = ~owner_q & s_rvalid;
            m1_rvalid = owner_q & s_rvalid;
            if (s_rvalid && r_ack) state_d = IDLE;
         end
         WADDR: begin
            s_awvalid = ~aw_done_q;
            s_wvalid  = ~w_done_q;
            aw_now    = aw_done_q | s_awready;
            w_now     = w_done_q | s_wready;
            if (aw_now && w_now) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = WRESP;
            end else begin
               aw_done_d = aw_now;
               w_done_d  = w_now;
            end
         end
         WRESP: begin
            m1_bvalid = s_bvalid;
            s_bready  = m1_bready;
            if (s_bvalid && m1_bready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         addr_q       <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         aw_done_q    <= aw_done_d;
         w_done_q     <= w_done_d;
      end
   end

endmodule
